// File: rtl/fp_pkg.sv
// Shared floating-point definitions for adder front-end controllers.
package fp_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned RMODE_W = 2;

    localparam logic FP_ADD = 1'b0;
    localparam logic FP_SUB = 1'b1;

    typedef enum logic [RMODE_W-1:0] {
        RM_NEAREST_EVEN = 2'd0,
        RM_TO_ZERO      = 2'd1,
        RM_POS_INF      = 2'd2,
        RM_NEG_INF      = 2'd3
    } rmode_e;

    // One adder operation as presented to the FP_Adder inputs.
    typedef struct packed {
        logic [FP_W-1:0]    a;
        logic [FP_W-1:0]    b;
        logic               mode;
        logic [RMODE_W-1:0] rmode;
    } fp_op_t;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester and adder-side bus of the shared FP adder arbiter.
interface fp_add_arbiter_if
    import fp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic                       Enable;
    logic [NUM_REQ-1:0]         Req_Valid;
    logic [NUM_REQ-1:0]         Req_Ready;
    logic [FP_W*NUM_REQ-1:0]    Req_Data_A;
    logic [FP_W*NUM_REQ-1:0]    Req_Data_B;
    logic [NUM_REQ-1:0]         Req_Mode;
    logic [RMODE_W*NUM_REQ-1:0] Req_RMode;
    logic [NUM_REQ-1:0]         Rsp_Valid;
    logic [FP_W-1:0]            Rsp_Data;
    logic [FP_W-1:0]            Add_Data_A;
    logic [FP_W-1:0]            Add_Data_B;
    logic                       Add_Mode;
    logic [RMODE_W-1:0]         Add_RMode;
    logic                       Add_Valid_In;
    logic [FP_W-1:0]            Add_Data_Out;
    logic                       Add_Valid_Out;
    logic                       Busy;
    logic                       Err;

    // Arbiter side.
    modport slave (
        input  Enable, Req_Valid, Req_Data_A, Req_Data_B, Req_Mode, Req_RMode,
        input  Add_Data_Out, Add_Valid_Out,
        output Req_Ready, Rsp_Valid, Rsp_Data,
        output Add_Data_A, Add_Data_B, Add_Mode, Add_RMode, Add_Valid_In,
        output Busy, Err
    );

    // Requesters plus attached adder.
    modport master (
        output Enable, Req_Valid, Req_Data_A, Req_Data_B, Req_Mode, Req_RMode,
        output Add_Data_Out, Add_Valid_Out,
        input  Req_Ready, Rsp_Valid, Rsp_Data,
        input  Add_Data_A, Add_Data_B, Add_Mode, Add_RMode, Add_Valid_In,
        input  Busy, Err
    );

endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Round-robin one-hot grant with a pointer that remembers the last winner.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [N-1:0]            i_req,
    output logic [N-1:0]            o_grant_c,
    output logic [$clog2(N)-1:0]    o_grant_idx_c,
    output logic                    o_grant_any_c
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;

    // Search from pointer+1 upward, wrapping, and take the first active request.
    always_comb begin
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        o_grant_any_c = 1'b0;
        w_cand        = '0;
        if (i_enable) begin
            for (int unsigned k = 1; k <= N; k++) begin
                w_cand = IDX_W'((32'(r_ptr) + k) % N);
                if (!o_grant_any_c && i_req[w_cand]) begin
                    o_grant_any_c     = 1'b1;
                    o_grant_idx_c     = w_cand;
                    o_grant_c[w_cand] = 1'b1;
                end
            end
        end
    end

    // Pointer follows the winner so it drops to lowest priority next time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= IDX_W'(N - 1);
        end else if (o_grant_any_c) begin
            r_ptr <= o_grant_idx_c;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined FP adder among NUM_REQ requesters and routes results back.
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic           Clk,
    input  logic           Reset_N,
    fp_add_arbiter_if.slave bus
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_any;
    logic               w_hs;
    fp_op_t             w_sel_op;

    fp_op_t             r_op;
    logic               r_issue_v;
    logic [ID_W-1:0]    r_issue_id;

    logic [ADD_LAT-1:0] r_tag_v;
    logic [ID_W-1:0]    r_tag_id [ADD_LAT];
    logic               w_tag_out_v;
    logic [ID_W-1:0]    w_tag_out_id;

    logic [NUM_REQ-1:0] r_rsp_v;
    logic [FP_W-1:0]    r_rsp_data;
    logic               r_err;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .i_clk         (Clk),
        .i_rst_n       (Reset_N),
        .i_enable      (bus.Enable),
        .i_req         (bus.Req_Valid),
        .o_grant_c     (w_grant),
        .o_grant_idx_c (w_grant_idx),
        .o_grant_any_c (w_grant_any)
    );

    assign w_hs         = w_grant_any && (|(bus.Req_Valid & w_grant));
    assign w_tag_out_v  = r_tag_v[ADD_LAT-1];
    assign w_tag_out_id = r_tag_id[ADD_LAT-1];

    // Pick the granted requester's operand slices.
    always_comb begin
        w_sel_op       = '0;
        w_sel_op.a     = bus.Req_Data_A[32'(w_grant_idx)*FP_W +: FP_W];
        w_sel_op.b     = bus.Req_Data_B[32'(w_grant_idx)*FP_W +: FP_W];
        w_sel_op.mode  = bus.Req_Mode[w_grant_idx];
        w_sel_op.rmode = bus.Req_RMode[32'(w_grant_idx)*RMODE_W +: RMODE_W];
    end

    // Issue register: one operation per cycle into the adder; data holds when idle.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_op       <= '0;
            r_issue_v  <= 1'b0;
            r_issue_id <= '0;
        end else begin
            r_issue_v <= w_hs;
            if (w_hs) begin
                r_op       <= w_sel_op;
                r_issue_id <= w_grant_idx;
            end
        end
    end

    // Tag pipe shadows the adder latency so each result knows its owner.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_tag_v <= '0;
            for (int unsigned i = 0; i < ADD_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_issue_v;
            r_tag_id[0] <= r_issue_id;
            for (int unsigned i = 1; i < ADD_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Route matched results back; any valid disagreement latches Err.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_rsp_v    <= '0;
            r_rsp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rsp_v <= '0;
            if (w_tag_out_v && bus.Add_Valid_Out) begin
                r_rsp_v    <= NUM_REQ'(1) << w_tag_out_id;
                r_rsp_data <= bus.Add_Data_Out;
            end
            if (w_tag_out_v != bus.Add_Valid_Out) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.Req_Ready    = w_grant;
    assign bus.Add_Data_A   = r_op.a;
    assign bus.Add_Data_B   = r_op.b;
    assign bus.Add_Mode     = r_op.mode;
    assign bus.Add_RMode    = r_op.rmode;
    assign bus.Add_Valid_In = r_issue_v;
    assign bus.Rsp_Valid    = r_rsp_v;
    assign bus.Rsp_Data     = r_rsp_data;
    assign bus.Busy         = r_issue_v | (|r_tag_v) | w_hs;
    assign bus.Err          = r_err;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter with a behavioural FP adder stub and a scoreboard.
module tb_fp_add_arbiter;
    import fp_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADD_LAT = 2;
    localparam int          RSP_LAT = ADD_LAT + 2;

    logic Clk     = 1'b0;
    logic Reset_N = 1'b0;
    logic force_vo = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int a_int [NUM_REQ];
    int b_int [NUM_REQ];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    fp_add_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    fp_add_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    // Exact small-integer to IEEE single conversion.
    function automatic logic [31:0] int2f(input int v);
        logic [31:0] m;
        logic [31:0] sh;
        int p;
        if (v == 0) return 32'h0;
        m = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int b = 0; b < 24; b++) if (m[b]) p = b;
        sh = m << (23 - p);
        return {(v < 0), 8'(127 + p), sh[22:0]};
    endfunction

    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'h0) return 0.0;
        d = {x[31], 11'(32'(x[30:23]) + 32'd896), x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return 32'h0;
        return {d[63], 8'(32'(d[62:52]) - 32'd896), d[51:29]};
    endfunction

    // Adder stub: fixed-latency pipe computing in real arithmetic.
    logic [ADD_LAT-1:0] stub_v;
    logic [31:0]        stub_d [ADD_LAT];
    always @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            stub_v <= '0;
            for (int i = 0; i < ADD_LAT; i++) stub_d[i] <= '0;
        end else begin
            stub_v[0] <= bus.Add_Valid_In;
            stub_d[0] <= bus.Add_Mode ? r2f(f2r(bus.Add_Data_A) - f2r(bus.Add_Data_B))
                                      : r2f(f2r(bus.Add_Data_A) + f2r(bus.Add_Data_B));
            for (int i = 1; i < ADD_LAT; i++) begin
                stub_v[i] <= stub_v[i-1];
                stub_d[i] <= stub_d[i-1];
            end
        end
    end
    assign bus.Add_Valid_Out = stub_v[ADD_LAT-1] | force_vo;
    assign bus.Add_Data_Out  = stub_d[ADD_LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: round-robin from the last winner, results due RSP_LAT cycles later.
    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];
    exp_t m_e;
    int   m_ptr = NUM_REQ - 1;
    int   m_gi;
    int   m_res;
    bit   m_resp;
    logic [NUM_REQ-1:0] m_exp_rdy;

    always @(negedge Clk) begin
        if (!Reset_N) begin
            q.delete();
            m_ptr = NUM_REQ - 1;
        end else begin
            m_gi = -1;
            m_exp_rdy = '0;
            if (bus.Enable) begin
                for (int k = 1; k <= NUM_REQ; k++)
                    if (m_gi < 0 && bus.Req_Valid[(m_ptr + k) % NUM_REQ]) m_gi = (m_ptr + k) % NUM_REQ;
            end
            if (m_gi >= 0) m_exp_rdy[m_gi] = 1'b1;
            check("ready", 64'(bus.Req_Ready), 64'(m_exp_rdy));

            m_resp = 1'b0;
            while (q.size() > 0 && cyc >= q[0].due) begin
                if (cyc == q[0].due && bus.Rsp_Valid != '0) begin
                    check("rsp_id", 64'(bus.Rsp_Valid), 64'(1 << q[0].id));
                    check("rsp_data", 64'(bus.Rsp_Data), 64'(q[0].data));
                    m_resp = 1'b1;
                end else begin
                    check("rsp_missing", 64'(bus.Rsp_Valid), 64'(1 << q[0].id));
                end
                void'(q.pop_front());
            end
            if (!m_resp) check("rsp_idle", 64'(bus.Rsp_Valid), 64'h0);

            if (m_gi >= 0) begin
                m_res  = bus.Req_Mode[m_gi] ? (a_int[m_gi] - b_int[m_gi]) : (a_int[m_gi] + b_int[m_gi]);
                m_e.id   = m_gi;
                m_e.data = int2f(m_res);
                m_e.due  = cyc + RSP_LAT;
                q.push_back(m_e);
                m_ptr = m_gi;
            end
            check("busy", 64'(bus.Busy), 64'((m_gi >= 0) || (q.size() > 0)));
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    task automatic set_req(input int i, input logic v, input int a, input int b,
                           input logic m, input logic [1:0] rm);
        a_int[i] = a;
        b_int[i] = b;
        bus.Req_Valid[i]             = v;
        bus.Req_Data_A[i*32 +: 32]   = int2f(a);
        bus.Req_Data_B[i*32 +: 32]   = int2f(b);
        bus.Req_Mode[i]              = m;
        bus.Req_RMode[i*2 +: 2]      = rm;
    endtask

    task automatic do_reset();
        next_cycle();
        Reset_N = 1'b0;
        bus.Req_Valid = '0;
        next_cycle();
        next_cycle();
        Reset_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Enable     = 1'b0;
        bus.Req_Valid  = '0;
        bus.Req_Data_A = '0;
        bus.Req_Data_B = '0;
        bus.Req_Mode   = '0;
        bus.Req_RMode  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin a_int[i] = 0; b_int[i] = 0; end

        // Reset state
        repeat (3) @(posedge Clk);
        sample();
        check("rst_ready", 64'(bus.Req_Ready), 64'h0);
        check("rst_rsp_valid", 64'(bus.Rsp_Valid), 64'h0);
        check("rst_rsp_data", 64'(bus.Rsp_Data), 64'h0);
        check("rst_add_valid", 64'(bus.Add_Valid_In), 64'h0);
        check("rst_add_a", 64'(bus.Add_Data_A), 64'h0);
        check("rst_busy", 64'(bus.Busy), 64'h0);
        check("rst_err", 64'(bus.Err), 64'h0);
        next_cycle();
        Reset_N    = 1'b1;
        bus.Enable = 1'b1;

        // Single request: 1.0 + 2.0
        next_cycle();
        set_req(0, 1'b1, 1, 2, FP_ADD, RM_NEAREST_EVEN);
        sample();
        check("t1_ready", 64'(bus.Req_Ready), 64'h1);
        next_cycle();
        bus.Req_Valid = '0;
        sample();
        check("t1_add_valid", 64'(bus.Add_Valid_In), 64'h1);
        check("t1_add_a", 64'(bus.Add_Data_A), 64'h3F800000);
        check("t1_add_b", 64'(bus.Add_Data_B), 64'h40000000);
        next_cycle();
        next_cycle();
        next_cycle();
        sample();
        check("t1_rsp_valid", 64'(bus.Rsp_Valid), 64'h1);
        check("t1_rsp_data", 64'(bus.Rsp_Data), 64'h40400000);
        next_cycle();
        sample();
        check("t1_busy_after", 64'(bus.Busy), 64'h0);

        // All four valid for 8 cycles; requester 2 computes 2.0 - 1.0
        do_reset();
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            if (k == 0) begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (i == 2) set_req(i, 1'b1, 2, 1, FP_SUB, RM_TO_ZERO);
                    else        set_req(i, 1'b1, i + 1, i + 5, FP_ADD, RM_NEAREST_EVEN);
            end
            if (k == 8) bus.Req_Valid = '0;
            sample();
            if (k < 8)  check("t2_grant", 64'(bus.Req_Ready), 64'(1 << (k % 4)));
            if (k >= 4) check("t2_rsp_order", 64'(bus.Rsp_Valid), 64'(1 << ((k - 4) % 4)));
            if (k == 6) check("t2_req2_data", 64'(bus.Rsp_Data), 64'h3F800000);
        end

        // Back-to-back from requester 1
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            if (k < 8) set_req(1, 1'b1, k + 1, 2 * k, FP_ADD, RM_POS_INF);
            else       bus.Req_Valid = '0;
            sample();
            if (k < 8) check("t3_grant", 64'(bus.Req_Ready), 64'h2);
            if (k >= 4) begin
                check("t3_rsp_valid", 64'(bus.Rsp_Valid), 64'h2);
                check("t3_rsp_data", 64'(bus.Rsp_Data), 64'(int2f(3 * (k - 4) + 1)));
            end
        end

        // Enable dropped for 3 cycles with requesters 0 and 3 pending
        next_cycle();
        set_req(0, 1'b1, 7, 3, FP_SUB, RM_NEG_INF);
        set_req(3, 1'b1, 5, 6, FP_ADD, RM_NEAREST_EVEN);
        sample();
        check("t4_grant_first", 64'(bus.Req_Ready), 64'h8);
        for (int j = 1; j <= 3; j++) begin
            next_cycle();
            bus.Enable = 1'b0;
            sample();
            check("t4_blocked", 64'(bus.Req_Ready), 64'h0);
        end
        next_cycle();
        bus.Enable = 1'b1;
        sample();
        check("t4_resume", 64'(bus.Req_Ready), 64'h1);
        check("t4_inflight_rsp", 64'(bus.Rsp_Valid), 64'h8);
        check("t4_inflight_data", 64'(bus.Rsp_Data), 64'(int2f(11)));
        next_cycle();
        bus.Req_Valid = '0;
        repeat (5) next_cycle();

        // Reset while two operations are in flight
        next_cycle();
        set_req(0, 1'b1, 4, 4, FP_ADD, RM_NEAREST_EVEN);
        next_cycle();
        set_req(0, 1'b1, 9, 1, FP_SUB, RM_NEAREST_EVEN);
        next_cycle();
        Reset_N = 1'b0;
        bus.Req_Valid = '0;
        sample();
        check("t5_rsp_valid", 64'(bus.Rsp_Valid), 64'h0);
        check("t5_rsp_data", 64'(bus.Rsp_Data), 64'h0);
        check("t5_add_valid", 64'(bus.Add_Valid_In), 64'h0);
        check("t5_add_a", 64'(bus.Add_Data_A), 64'h0);
        check("t5_busy", 64'(bus.Busy), 64'h0);
        check("t5_err", 64'(bus.Err), 64'h0);
        next_cycle();
        next_cycle();
        Reset_N = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample();
            check("t5_no_rsp", 64'(bus.Rsp_Valid), 64'h0);
            next_cycle();
        end

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            next_cycle();
            bus.Enable = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NUM_REQ; i++)
                set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(1, 1000)),
                        int'($urandom_range(1, 1000)), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)));
        end
        next_cycle();
        bus.Req_Valid = '0;
        bus.Enable    = 1'b1;
        repeat (8) next_cycle();
        sample();
        check("rand_drained", 64'(q.size()), 64'h0);
        check("rand_err", 64'(bus.Err), 64'h0);

        // Adder valid with empty tag pipe
        next_cycle();
        force_vo = 1'b1;
        sample();
        check("t6_err_before", 64'(bus.Err), 64'h0);
        next_cycle();
        force_vo = 1'b0;
        sample();
        check("t6_err_set", 64'(bus.Err), 64'h1);
        check("t6_no_rsp", 64'(bus.Rsp_Valid), 64'h0);
        repeat (3) next_cycle();
        sample();
        check("t6_err_sticky", 64'(bus.Err), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one pipelined FP_Adder instance among NUM_REQ requesters, such as the NNEVision accumulator and bias lanes.
- Grants requests round-robin and issues one operation per cycle through a registered stage.
- Carries the requester ID alongside the adder latency and routes each result back to its originator.
- Flags any mismatch between issued operations and adder outputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADD_LAT, 2, cycles from Add_Valid_In to Add_Valid_Out of the attached adder (>=1).
- ID_W, $clog2(NUM_REQ), derived; width of the internal requester tag.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_N  in  1  asynchronous active-low reset.
- Enable  in  1  when low, no new grants; in-flight operations drain.
- Req_Valid  in  NUM_REQ  per-requester operation request.
- Req_Ready  out  NUM_REQ  one-hot grant; handshake occurs when Req_Valid[i] and Req_Ready[i] are both high.
- Req_Data_A  in  32*NUM_REQ  operand A, slice i belongs to requester i.
- Req_Data_B  in  32*NUM_REQ  operand B.
- Req_Mode  in  NUM_REQ  0 = add, 1 = subtract.
- Req_RMode  in  2*NUM_REQ  rounding mode per requester.
- Rsp_Valid  out  NUM_REQ  one-hot result strobe, single cycle.
- Rsp_Data  out  32  result, shared bus, qualified by Rsp_Valid.
- Add_Data_A  out  32  to FP_Adder Data_A.
- Add_Data_B  out  32  to FP_Adder Data_B.
- Add_Mode  out  1  to FP_Adder Mode.
- Add_RMode  out  2  to FP_Adder RMode.
- Add_Valid_In  out  1  to FP_Adder Valid_In.
- Add_Data_Out  in  32  from FP_Adder Data_Out.
- Add_Valid_Out  in  1  from FP_Adder Valid_Out.
- Busy  out  1  high while any operation is in flight or being issued.
- Err  out  1  sticky protocol-error flag.

Behaviour:

Reset:
- All outputs are 0.
- Grant pointer is NUM_REQ-1, so requester 0 has highest priority first.
- Tag pipe is empty and Err is cleared.
- Reset asserted mid-operation discards all in-flight results; no Rsp_Valid follows the release of reset.

Arbitration (combinational):
- Req_Ready is one-hot.
- Search order starts at pointer+1 and wraps modulo NUM_REQ; the first requester with Req_Valid high is granted.
- Req_Ready is all-zero when Enable is 0 or no request is pending.
- Req_Ready may depend on Req_Valid; requesters must not make Req_Valid depend on Req_Ready.

Pointer:
- Loads the granted index on a handshake.
- Holds when there is no grant.
- Guarantees no starvation: any continuously valid requester is granted within NUM_REQ cycles.

Issue stage (registered):
- On a handshake, the next edge loads Add_Data_A/B/Mode/RMode from the granted slices and sets Add_Valid_In = 1.
- Without a handshake, Add_Valid_In = 0 and the data registers hold their values.
- Throughput is one operation per cycle.

Tag pipe:
- ADD_LAT-deep shift register of {valid, ID}, advanced every cycle.
- Entry written from the issue stage (valid = Add_Valid_In).

Response:
- When the tag-pipe output is valid and Add_Valid_Out = 1, the next edge sets Rsp_Data = Add_Data_Out and Rsp_Valid = one-hot(ID).
- Otherwise Rsp_Valid = 0 and Rsp_Data holds its value.
- Responses are never back-pressured; requesters must accept.

Latency:
- Handshake at cycle t gives Add_Valid_In at t+1 and Rsp_Valid at t+1+ADD_LAT+1.
- With the default ADD_LAT = 2, Rsp_Valid arrives at t+4.
- Results return in issue order.

Err (sticky until reset):
- Set when Add_Valid_Out differs from the tag-pipe output valid bit in any cycle.
- On a mismatch no Rsp_Valid is issued for that cycle.

Busy:
- Busy = Add_Valid_In OR any tag-pipe valid OR any handshake this cycle.

Enable:
- Deasserting Enable mid-stream blocks new grants only.
- Pending tags complete normally.

Decomposition:
- Shared package fp_pkg holds:
  - FP_W = 32 and RMODE_W = 2;
  - mode constants FP_ADD = 0 and FP_SUB = 1;
  - rounding constants RM_NEAREST_EVEN = 0, RM_TO_ZERO = 1, RM_POS_INF = 2, RM_NEG_INF = 3.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin grant with pointer), reusable by other shared-resource controllers.

Test Plan:
1. Single request: Req_Valid = 0001, A = 0x3F800000, B = 0x40000000, Mode = 0, ADD_LAT = 2 -> Add_Valid_In at t+1 and Rsp_Valid = 0001 at t+4 with Rsp_Data = 0x40400000; Busy is low afterwards.
2. All four requesters valid continuously for 8 cycles, Req 2 subtracting 0x40000000 - 0x3F800000 -> grant order 0,1,2,3,0,1,2,3; responses in the same order; Req 2 receives 0x3F800000.
3. Back-to-back from one requester (Req 1 held valid, operands changed each cycle) -> one handshake per cycle; Rsp_Valid[1] high for 8 consecutive cycles with matching results.
4. Enable dropped for 3 cycles while Req 0 and Req 3 are valid -> Req_Ready = 0 throughout; in-flight results still return; the pointer resumes from the last grant.
5. Reset_N pulsed low while 2 operations are in flight -> outputs and Err go to 0 immediately; no Rsp_Valid appears after release.
6. Stub drives Add_Valid_Out = 1 with the tag pipe empty -> Err = 1 on the next edge and stays high; Rsp_Valid remains 0 for that beat.
